// File: rtl/mem_access_controller_pkg.sv
// Shared types for the main-memory initiator.
// Size encodings, FSM states and the alignment rule.
package mem_access_controller_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_e;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic bad;
    unique case (1'b1)
      size == SIZE_BYTE: bad = 1'b0;
      size == SIZE_HALF: bad = off[0];
      size == SIZE_WORD: bad = |off;
      default:           bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Byte/half lane extraction for loads and lane merge
// for read-modify-write stores, little-endian.
module mem_lane_unit
  import mem_access_controller_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] store_data_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    shifted = word_i >> {off_i, 3'b000};
    b       = shifted[7:0];
    h       = off_i[1] ? word_i[31:16] : word_i[15:0];
    load_o  = word_i;
    merge_o = store_data_i;
    unique case (1'b1)
      size_i == SIZE_BYTE: begin
        load_o  = {{24{signed_i & b[7]}}, b};
        merge_o = word_i;
        merge_o[{off_i, 3'b000} +: 8] = store_data_i[7:0];
      end
      size_i == SIZE_HALF: begin
        load_o  = {{16{signed_i & h[15]}}, h};
        merge_o = word_i;
        if (off_i[1]) merge_o[31:16] = store_data_i[15:0];
        else          merge_o[15:0]  = store_data_i[15:0];
      end
      default: begin
        load_o  = word_i;
        merge_o = store_data_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_controller.sv
// Load/store initiator for the main-memory port.
// Sub-word stores run as read-modify-write.
module mem_access_controller
  import mem_access_controller_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [1:0]        reqSize,
  input  logic              reqSigned,
  input  logic [ADDR_W-1:0] reqAddress,
  input  logic [31:0]       reqWriteData,
  output logic              respValid,
  input  logic              respReady,
  output logic [31:0]       respData,
  output logic              respError,
  output logic [ADDR_W-1:0] memAddress,
  output logic              memReadEnable,
  output logic              memWriteEnable,
  output logic [31:0]       memDataIn,
  input  logic [31:0]       memDataOut
);

  localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              write_q, write_d;
  logic              signed_q, signed_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-3:0] maddr_q, maddr_d;
  logic [31:0]       mdin_q, mdin_d;

  logic [31:0] load_val;
  logic [31:0] merge_val;
  logic        accept;
  logic        mis;

  mem_lane_unit u_lane (
    .word_i       (memDataOut),
    .store_data_i (wdata_q),
    .off_i        (off_q),
    .size_i       (size_q),
    .signed_i     (signed_q),
    .load_o       (load_val),
    .merge_o      (merge_val)
  );

  assign reqReady       = (state_q == IDLE) && !reset;
  assign respValid      = (state_q == RESP) && !reset;
  assign respError      = err_q;
  assign respData       = data_q;
  assign memReadEnable  = (state_q == READ) && !reset;
  assign memWriteEnable = (state_q == WRITE) && !reset;
  assign memAddress     = {maddr_q, 2'b00};
  assign memDataIn      = mdin_q;

  assign accept = reqValid && reqReady;
  assign mis    = misaligned(reqSize, reqAddress[1:0]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    size_d   = size_q;
    write_d  = write_q;
    signed_d = signed_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    data_d   = data_q;
    maddr_d  = maddr_q;
    mdin_d   = mdin_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          off_d    = reqAddress[1:0];
          size_d   = reqSize;
          write_d  = reqWrite;
          signed_d = reqSigned;
          wdata_d  = reqWriteData;
          cnt_d    = 4'd0;
          data_d   = 32'd0;
          err_d    = mis;
          if (mis) begin
            state_d = RESP;
          end else begin
            // Memory address only moves for real accesses.
            maddr_d = reqAddress[ADDR_W-1:2];
            if (reqWrite && reqSize == SIZE_WORD) begin
              mdin_d  = reqWriteData;
              state_d = WRITE;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        if (cnt_q == LAST) begin
          if (write_q) begin
            mdin_d  = merge_val;
            state_d = WRITE;
          end else begin
            data_d  = load_val;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WRITE: state_d = RESP;
      RESP: begin
        if (respReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      off_q    <= 2'd0;
      size_q   <= 2'd0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
      data_q   <= 32'd0;
      maddr_q  <= '0;
      mdin_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      off_q    <= off_d;
      size_q   <= size_d;
      write_q  <= write_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      data_q   <= data_d;
      maddr_q  <= maddr_d;
      mdin_q   <= mdin_d;
    end
  end

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench: two controllers (latency 1 and 3),
// each with its own behavioural memory.
module tb_mem_access_controller;

  logic        clk;
  logic        ra, rb, va, vb;
  logic        reqWrite, reqSigned, respReady;
  logic [1:0]  reqSize;
  logic [31:0] reqAddress, reqWriteData;

  logic        a_rdy, a_rv, a_re, a_mre, a_mwe;
  logic [31:0] a_rd, a_mad, a_mdi, a_mdo;
  logic        b_rdy, b_rv, b_re, b_mre, b_mwe;
  logic [31:0] b_rd, b_mad, b_mdi, b_mdo;

  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];

  int total = 0;
  int bad   = 0;

  mem_access_controller #(.MEM_LATENCY(1), .ADDR_W(32)) u_a (
    .clk(clk), .reset(ra),
    .reqValid(va), .reqReady(a_rdy),
    .reqWrite(reqWrite), .reqSize(reqSize),
    .reqSigned(reqSigned), .reqAddress(reqAddress),
    .reqWriteData(reqWriteData),
    .respValid(a_rv), .respReady(respReady),
    .respData(a_rd), .respError(a_re),
    .memAddress(a_mad), .memReadEnable(a_mre),
    .memWriteEnable(a_mwe), .memDataIn(a_mdi),
    .memDataOut(a_mdo)
  );

  mem_access_controller #(.MEM_LATENCY(3), .ADDR_W(32)) u_b (
    .clk(clk), .reset(rb),
    .reqValid(vb), .reqReady(b_rdy),
    .reqWrite(reqWrite), .reqSize(reqSize),
    .reqSigned(reqSigned), .reqAddress(reqAddress),
    .reqWriteData(reqWriteData),
    .respValid(b_rv), .respReady(respReady),
    .respData(b_rd), .respError(b_re),
    .memAddress(b_mad), .memReadEnable(b_mre),
    .memWriteEnable(b_mwe), .memDataIn(b_mdi),
    .memDataOut(b_mdo)
  );

  assign a_mdo = mem_a[a_mad[7:2]];
  assign b_mdo = mem_b[b_mad[7:2]];

  always @(posedge clk) begin
    if (a_mwe) mem_a[a_mad[7:2]] <= a_mdi;
    if (b_mwe) mem_b[b_mad[7:2]] <= b_mdi;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_req(
    input  bit          sel,
    input  logic        w,
    input  logic [1:0]  sz,
    input  logic        sg,
    input  logic [31:0] ad,
    input  logic [31:0] wd,
    output logic [31:0] data,
    output logic        err,
    output int          edges,
    output int          rdc,
    output int          wrc,
    output logic [31:0] wraddr
  );
    reqWrite     = w;
    reqSize      = sz;
    reqSigned    = sg;
    reqAddress   = ad;
    reqWriteData = wd;
    respReady    = 1'b1;
    if (sel) vb = 1'b1;
    else     va = 1'b1;
    @(posedge clk);
    #1;
    va = 1'b0;
    vb = 1'b0;
    edges  = 1;
    rdc    = 0;
    wrc    = 0;
    wraddr = 32'd0;
    for (int i = 0; i < 40; i++) begin
      if (sel ? b_rv : a_rv) break;
      if (sel ? b_mre : a_mre) rdc++;
      if (sel ? b_mwe : a_mwe) begin
        wrc++;
        wraddr = sel ? b_mad : a_mad;
      end
      @(posedge clk);
      edges++;
      #1;
    end
    total++;
    if (!(sel ? b_rv : a_rv)) begin
      bad++;
      $display("FAIL resp_timeout: respValid=0 required 1");
    end
    data = sel ? b_rd : a_rd;
    err  = sel ? b_re : a_re;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++;
    if (a_rdy !== 1'b0) begin
      bad++; $display("FAIL rst_ready: got %b want 0", a_rdy);
    end
    total++;
    if (a_rv !== 1'b0 || a_re !== 1'b0) begin
      bad++; $display("FAIL rst_resp: got v=%b e=%b want 0", a_rv, a_re);
    end
    total++;
    if (a_rd !== 32'd0 || a_mad !== 32'd0 || a_mdi !== 32'd0) begin
      bad++;
      $display("FAIL rst_data: got rd=%h ad=%h di=%h want 0",
               a_rd, a_mad, a_mdi);
    end
    total++;
    if (a_mre !== 1'b0 || a_mwe !== 1'b0 || b_mre !== 1'b0) begin
      bad++; $display("FAIL rst_strobe: got re=%b we=%b want 0", a_mre, a_mwe);
    end
  endtask

  task automatic test_word();
    logic [31:0] d, wa;
    logic        e;
    int          ed, rc, wc;
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, d, e, ed, rc, wc, wa);
    total++;
    if (wc !== 1 || rc !== 0 || wa !== 32'h10) begin
      bad++;
      $display("FAIL sw_strobe: got wr=%0d rd=%0d ad=%h want 1 0 10", wc, rc, wa);
    end
    total++;
    if (ed !== 2 || e !== 1'b0 || d !== 32'd0) begin
      bad++;
      $display("FAIL sw_resp: got edges=%0d err=%b d=%h want 2 0 0", ed, e, d);
    end
    total++;
    if (mem_a[4] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL sw_mem: got %h want deadbeef", mem_a[4]);
    end
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, d, e, ed, rc, wc, wa);
    total++;
    if (d !== 32'hDEADBEEF || e !== 1'b0 || ed !== 2 || rc !== 1) begin
      bad++;
      $display("FAIL lw: got d=%h e=%b edges=%0d rd=%0d want deadbeef 0 2 1",
               d, e, ed, rc);
    end
  endtask

  task automatic test_byte();
    logic [31:0] d, wa;
    logic        e;
    int          ed, rc, wc;
    do_req(0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h123456AB, d, e, ed, rc, wc, wa);
    total++;
    if (rc !== 1 || wc !== 1 || ed !== 3 || e !== 1'b0) begin
      bad++;
      $display("FAIL sb_seq: got rd=%0d wr=%0d edges=%0d e=%b want 1 1 3 0",
               rc, wc, ed, e);
    end
    total++;
    if (mem_a[4] !== 32'hDEADABEF) begin
      bad++; $display("FAIL sb_mem: got %h want deadabef", mem_a[4]);
    end
    do_req(0, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, d, e, ed, rc, wc, wa);
    total++;
    if (d !== 32'hFFFFFFAB) begin
      bad++; $display("FAIL lb_signed: got %h want ffffffab", d);
    end
    do_req(0, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, d, e, ed, rc, wc, wa);
    total++;
    if (d !== 32'h000000AB) begin
      bad++; $display("FAIL lbu: got %h want 000000ab", d);
    end
  endtask

  task automatic test_half();
    logic [31:0] d, wa;
    logic        e;
    int          ed, rc, wc;
    do_req(0, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, d, e, ed, rc, wc, wa);
    total++;
    if (d !== 32'hFFFFDEAD) begin
      bad++; $display("FAIL lh_signed: got %h want ffffdead", d);
    end
    do_req(0, 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, d, e, ed, rc, wc, wa);
    total++;
    if (d !== 32'h0000ABEF) begin
      bad++; $display("FAIL lhu: got %h want 0000abef", d);
    end
  endtask

  task automatic test_errors();
    logic [31:0] d, wa;
    logic        e;
    int          ed, rc, wc;
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h13, 32'h0, d, e, ed, rc, wc, wa);
    total++;
    if (e !== 1'b1 || d !== 32'd0 || ed !== 1 || rc !== 0 || wc !== 0) begin
      bad++;
      $display("FAIL err_lw13: got e=%b d=%h edges=%0d want 1 0 1", e, d, ed);
    end
    do_req(0, 1'b1, 2'd3, 1'b0, 32'h10, 32'h55, d, e, ed, rc, wc, wa);
    total++;
    if (e !== 1'b1 || d !== 32'd0 || ed !== 1 || wc !== 0) begin
      bad++;
      $display("FAIL err_size3: got e=%b d=%h edges=%0d want 1 0 1", e, d, ed);
    end
    total++;
    if (mem_a[4] !== 32'hDEADABEF) begin
      bad++; $display("FAIL err_mem: got %h want deadabef", mem_a[4]);
    end
  endtask

  task automatic test_backpressure();
    reqWrite   = 1'b0;
    reqSize    = 2'd2;
    reqSigned  = 1'b0;
    reqAddress = 32'h10;
    respReady  = 1'b0;
    va         = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      if (a_rv) break;
      @(posedge clk);
      #1;
    end
    reqAddress = 32'h14;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (a_rv !== 1'b1 || a_rd !== 32'hDEADABEF || a_re !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: got v=%b d=%h e=%b want 1 deadabef 0",
                 k, a_rv, a_rd, a_re);
      end
      total++;
      if (a_rdy !== 1'b0) begin
        bad++; $display("FAIL bp_ready%0d: got %b want 0", k, a_rdy);
      end
    end
    respReady = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (a_rv !== 1'b0 || a_rdy !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got v=%b rdy=%b want 0 1", a_rv, a_rdy);
    end
    @(posedge clk);
    #1;
    va = 1'b0;
    total++;
    if (a_rdy !== 1'b0) begin
      bad++; $display("FAIL bp_accept: got rdy=%b want 0", a_rdy);
    end
    for (int i = 0; i < 20; i++) begin
      if (a_rv) break;
      @(posedge clk);
      #1;
    end
    total++;
    if (a_rv !== 1'b1 || a_rd !== 32'h01234567) begin
      bad++;
      $display("FAIL bp_second: got v=%b d=%h want 1 01234567", a_rv, a_rd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    reqWrite     = 1'b1;
    reqSize      = 2'd0;
    reqSigned    = 1'b0;
    reqAddress   = 32'h10;
    reqWriteData = 32'h55;
    respReady    = 1'b1;
    va           = 1'b1;
    @(posedge clk);
    #1;
    va = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (a_mwe) break;
      @(posedge clk);
      #1;
    end
    total++;
    if (a_mwe !== 1'b1) begin
      bad++; $display("FAIL rm_write: got we=%b want 1", a_mwe);
    end
    ra = 1'b1;
    #1;
    total++;
    if (a_mwe !== 1'b0 || a_rdy !== 1'b0) begin
      bad++;
      $display("FAIL rm_drop: got we=%b rdy=%b want 0 0", a_mwe, a_rdy);
    end
    @(posedge clk);
    #1;
    total++;
    if (mem_a[4] !== 32'hDEADABEF) begin
      bad++; $display("FAIL rm_mem: got %h want deadabef", mem_a[4]);
    end
    @(negedge clk);
    ra = 1'b0;
    #1;
    total++;
    if (a_rdy !== 1'b1 || a_rv !== 1'b0) begin
      bad++;
      $display("FAIL rm_after: got rdy=%b v=%b want 1 0", a_rdy, a_rv);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency3();
    logic [31:0] d, wa;
    logic        e;
    int          ed, rc, wc;
    do_req(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, d, e, ed, rc, wc, wa);
    total++;
    if (ed !== 2 || wc !== 1 || rc !== 0 || mem_b[4] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL l3_sw: got edges=%0d wr=%0d mem=%h want 2 1 deadbeef",
               ed, wc, mem_b[4]);
    end
    do_req(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, d, e, ed, rc, wc, wa);
    total++;
    if (ed !== 4 || rc !== 3 || d !== 32'hDEADBEEF || e !== 1'b0) begin
      bad++;
      $display("FAIL l3_lw: got edges=%0d rd=%0d d=%h want 4 3 deadbeef",
               ed, rc, d);
    end
  endtask

  always @(negedge clk) begin
    if (!ra && a_mre && a_mwe) begin
      total++;
      bad++;
      $display("FAIL strobe_overlap: got re=1 we=1 want exclusive");
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 32'd0;
      mem_b[i] = 32'd0;
    end
    mem_a[5]     = 32'h01234567;
    ra           = 1'b1;
    rb           = 1'b1;
    va           = 1'b0;
    vb           = 1'b0;
    reqWrite     = 1'b0;
    reqSize      = 2'd0;
    reqSigned    = 1'b0;
    reqAddress   = 32'd0;
    reqWriteData = 32'd0;
    respReady    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    ra = 1'b0;
    rb = 1'b0;
    @(posedge clk);
    #1;
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_latency3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
Initiator side of the main-memory port. Accepts load/store requests from the pipeline over a valid/ready handshake and drives the memory's address, readEnable, writeEnable and dataIn. It captures the memory's combinational dataOut and returns load data and status to the pipeline. Sub-word stores are done as read-modify-write, because the memory only writes whole 32-bit words.

Parameters:
MEM_LATENCY, 1, cycles the address is held with readEnable high before dataOut is sampled; legal range 1..15.
ADDR_W, 32, address width on both sides.

Ports:
clk  input  1  single clock; all state changes on posedge.
reset  input  1  asynchronous, active-high reset.
reqValid  input  1  pipeline request valid.
reqReady  output  1  controller can accept a request.
reqWrite  input  1  1 = store, 0 = load.
reqSize  input  2  0 byte, 1 half, 2 word; 3 is treated as misaligned/illegal.
reqSigned  input  1  sign-extend sub-word loads.
reqAddress  input  ADDR_W  byte address.
reqWriteData  input  32  store data, right-aligned.
respValid  output  1  response available.
respReady  input  1  pipeline accepts the response.
respData  output  32  load result; 0 for stores and errors.
respError  output  1  misaligned or illegal request.
memAddress  output  ADDR_W  word-aligned address to memory (low 2 bits are 0).
memReadEnable  output  1  read strobe.
memWriteEnable  output  1  write strobe; memory writes at the next posedge.
memDataIn  output  32  write data to memory.
memDataOut  input  32  combinational read data from memory.

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP.
- Reset (asynchronous): state=IDLE, latency counter=0, all latched request fields cleared.
- Output values under reset: reqReady=0 (gated by reset), respValid=0, respError=0, respData=0, memReadEnable=0, memWriteEnable=0, memAddress=0, memDataIn=0.
- Reset mid-operation: the strobes drop in the same cycle reset rises, so no write is committed and the transaction is discarded with no response.
- IDLE:
  - reqReady=1; a request is accepted on a posedge with reqValid&reqReady, and all req* fields are latched.
  - Misaligned when: size 1 with addr[0]=1; size 2 with addr[1:0]≠0; or size 3. A misaligned request goes to RESP with respError=1 and no memory strobes.
  - Load, or sub-word store → READ.
  - Word store → WRITE.
- READ:
  - memReadEnable=1, memWriteEnable=0, memAddress = latched address with bits [1:0] forced to 0.
  - The counter runs 0..MEM_LATENCY-1. On the last cycle memDataOut is captured.
  - Load: extract the lane, zero- or sign-extend, → RESP.
  - Sub-word store: merge store data into the captured word, → WRITE.
- WRITE:
  - Lasts exactly one cycle: memWriteEnable=1, memReadEnable=0, memDataIn = word or merged word, → RESP.
- RESP:
  - respValid=1; respData and respError stay stable until respValid&respReady at a posedge, then → IDLE.
  - reqReady=0 in every state except IDLE, so one transaction is outstanding at most.
- Lanes are little-endian: byte n = bits [8n+7:8n] selected by addr[1:0]; a half uses addr[1]. Sign extension copies bit 7 or bit 15.
- Latency, counted from the acceptance edge:
  - Load: respValid rises after MEM_LATENCY+1 edges.
  - Word store: write commits at edge 2; respValid is high in the cycle after.
  - Sub-word store: MEM_LATENCY+2 edges to respValid.
  - Error: 1 edge to respValid.
- memReadEnable and memWriteEnable are never high together.
- Outside READ and WRITE, memAddress and memDataIn hold their last values. memDataIn is 0 after reset.

Decomposition:
- Shared package holds:
  - size constants SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2;
  - the state enum (IDLE, READ, WRITE, RESP);
  - an alignment-check function.
- One sub-module: mem_lane_unit (combinational).
  - Extract: (word, addr[1:0], size, signed) → load value.
  - Merge: (word, storeData, addr[1:0], size) → merged word.
  - Unit-testable on its own.

Test Plan:
1. Store word 0xDEADBEEF @0x10, then load word @0x10 → respData=0xDEADBEEF, respError=0. memWriteEnable is high exactly 1 cycle with memAddress=0x10.
2. After (1), store byte 0xAB @0x11 → one READ then one WRITE, and memory[0x10]=0xDEADABEF. Load signed byte @0x11 → 0xFFFFFFAB; unsigned → 0x000000AB.
3. Load half signed @0x12 of 0xDEADABEF → 0xFFFFDEAD; unsigned half @0x10 → 0x0000ABEF.
4. Load word @0x13, or size=3 @0x10 → respError=1, respData=0 one edge after acceptance, and memReadEnable/memWriteEnable never asserted.
5. Hold respReady=0 for 3 cycles after respValid → respValid, respData and respError are stable, reqReady=0, and a pending reqValid is not accepted until the cycle after the response handshake.
6. Assert reset during WRITE of a byte store to 0x10 → memWriteEnable falls in that cycle, memory[0x10] is unchanged, and after release reqReady=1 with respValid=0. Also repeat (1) with MEM_LATENCY=3 → memReadEnable is high 3 cycles and load latency is 4 edges.
